// File: rtl/multi_alarm_clock_pkg.sv
// Shared types and constants for multi_alarm_clock and its keypad entry buffer.
// The optional snooze feature is selected by MULTI_ALARM_SNOOZE_EN.
package multi_alarm_clock_pkg;

    localparam logic [3:0]  NOKEY           = 4'd10;
    localparam logic [7:0]  ASCII_ZERO      = 8'h30;
    localparam int unsigned ENTRY_TIMEOUT_S = 10;

    typedef enum logic [1:0] {
        SHOW_TIME,
        ENTRY,
        SHOW_ALARM
    } state_t;

    typedef struct packed {
        logic [3:0] ms_hr;
        logic [3:0] ls_hr;
        logic [3:0] ms_min;
        logic [3:0] ls_min;
    } hhmm_t;

    function automatic hhmm_t to_hhmm(input logic [4:0] hr, input logic [5:0] mn);
        hhmm_t r;
        r.ms_hr  = 4'(hr / 5'd10);
        r.ls_hr  = 4'(hr % 5'd10);
        r.ms_min = 4'(mn / 6'd10);
        r.ls_min = 4'(mn % 6'd10);
        return r;
    endfunction

    function automatic logic [4:0] hhmm_hours(input hhmm_t v);
        return 5'(v.ms_hr) * 5'd10 + 5'(v.ls_hr);
    endfunction

    function automatic logic [5:0] hhmm_minutes(input hhmm_t v);
        return 6'(v.ms_min) * 6'd10 + 6'(v.ls_min);
    endfunction

endpackage

// File: rtl/multi_alarm_clock_digit_entry_shift.sv
// Keypad edge detection, four-digit left-shifting entry buffer and HH:MM validity flag.
module digit_entry_shift
    import multi_alarm_clock_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [3:0]  key_i,
    input  logic        enable_i,
    input  logic        fresh_i,
    input  logic        clear_i,
    output logic        accept_o,
    output logic [15:0] entry_o,
    output logic        valid_o
);

    logic [3:0]  key_prev_q;
    logic [15:0] buf_q, buf_d;

    // Only a NOKEY->digit transition counts, so a held key is taken once.
    assign accept_o = (key_prev_q == NOKEY) && (key_i < NOKEY);

    always_comb begin
        buf_d = buf_q;
        if (clear_i) begin
            buf_d = '0;
        end else if (enable_i && accept_o) begin
            buf_d = fresh_i ? {12'h000, key_i} : {buf_q[11:0], key_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            key_prev_q <= NOKEY;
            buf_q      <= '0;
        end else begin
            key_prev_q <= key_i;
            buf_q      <= buf_d;
        end
    end

    assign entry_o = buf_q;
    assign valid_o = ((buf_q[15:12] < 4'd2) || (buf_q[15:12] == 4'd2 && buf_q[11:8] <= 4'd3))
                     && (buf_q[7:4] <= 4'd5);

endmodule

// File: rtl/multi_alarm_clock.sv
// 24-hour timekeeper with NUM_ALARMS stored alarms, keypad entry and alarm timeout.
// Define MULTI_ALARM_SNOOZE_EN to build the snooze feature.
module multi_alarm_clock
    import multi_alarm_clock_pkg::*;
#(
    parameter  int unsigned CLK_HZ      = 256,
    parameter  int unsigned NUM_ALARMS  = 4,
    parameter  int unsigned TIMEOUT_MIN = 2,
    parameter  int unsigned SNOOZE_MIN  = 5,
    localparam int unsigned SEL_W       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alarm_button,
    input  logic             time_button,
    input  logic [3:0]       key,
    input  logic [SEL_W-1:0] alarm_sel,
    input  logic             fast_watch,
    input  logic             stop_alarm,
    input  logic             snooze,
    output logic             sound_alarm,
    output logic [SEL_W-1:0] alarm_id,
    output logic [7:0]       display_ms_hr,
    output logic [7:0]       display_ls_hr,
    output logic [7:0]       display_ms_min,
    output logic [7:0]       display_ls_min
);

    localparam int unsigned PW   = $clog2(CLK_HZ);
    localparam int unsigned EW   = $clog2(ENTRY_TIMEOUT_S * CLK_HZ);
    localparam int unsigned TO_W = (TIMEOUT_MIN > 1) ? $clog2(TIMEOUT_MIN) : 1;

    logic [PW-1:0]   presc_q;
    logic [5:0]      sec_q, min_q, min_nx;
    logic [4:0]      hr_q, hr_nx;
    state_t          state_q, state_d;
    logic [EW-1:0]   ent_cnt_q;
    hhmm_t           alarm_q [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] alarm_en_q;
    logic            sound_q, sound_d;
    logic [SEL_W-1:0] id_q, id_d, hit_id;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [31:0]     disp_q, disp_d;

    logic   sec_tick, min_tick, tick_eff, hit, sel_ok, timeout;
    logic   load_time, store_alarm, buf_clear, accept, entry_valid;
    hhmm_t  entry, now_nx, shown;

    digit_entry_shift u_entry (
        .clk_i    (clk),
        .reset_i  (reset),
        .key_i    (key),
        .enable_i (state_q == SHOW_TIME || state_q == ENTRY),
        .fresh_i  (state_q == SHOW_TIME),
        .clear_i  (buf_clear),
        .accept_o (accept),
        .entry_o  (entry),
        .valid_o  (entry_valid)
    );

    assign sec_tick = (presc_q == PW'(CLK_HZ - 1));
    assign min_tick = fast_watch || (sec_tick && sec_q == 6'd59);
    assign tick_eff = min_tick && !load_time;
    assign min_nx   = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
    assign hr_nx    = (min_q != 6'd59) ? hr_q : (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
    assign now_nx   = to_hhmm(hr_nx, min_nx);
    assign sel_ok   = (32'(alarm_sel) < NUM_ALARMS);
    assign timeout  = (ent_cnt_q == EW'(ENTRY_TIMEOUT_S * CLK_HZ - 1));

    always_comb begin
        state_d     = state_q;
        load_time   = 1'b0;
        store_alarm = 1'b0;
        buf_clear   = 1'b0;
        case (state_q)
            SHOW_TIME: begin
                if (accept)            state_d = ENTRY;
                else if (alarm_button) state_d = SHOW_ALARM;
            end
            ENTRY: begin
                if (time_button) begin
                    load_time = entry_valid;
                    state_d   = SHOW_TIME;
                    buf_clear = 1'b1;
                end else if (alarm_button) begin
                    store_alarm = entry_valid && sel_ok;
                    state_d     = SHOW_TIME;
                    buf_clear   = 1'b1;
                end else if (timeout) begin
                    state_d   = SHOW_TIME;
                    buf_clear = 1'b1;
                end
            end
            SHOW_ALARM: if (!alarm_button) state_d = SHOW_TIME;
            default:    state_d = SHOW_TIME;
        endcase
    end

    always_comb begin
        hit    = 1'b0;
        hit_id = '0;
        for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
            if (!hit && alarm_en_q[i] && alarm_q[i] == now_nx) begin
                hit    = 1'b1;
                hit_id = SEL_W'(i);
            end
        end
    end

`ifdef MULTI_ALARM_SNOOZE_EN
    logic        pend_q, pend_d;
    logic [10:0] tgt_q, tgt_d, now_total, nx_total, snz_sum;
    assign now_total = 11'(hr_q) * 11'd60 + 11'(min_q);
    assign nx_total  = 11'(hr_nx) * 11'd60 + 11'(min_nx);
    assign snz_sum   = now_total + 11'(SNOOZE_MIN);
`else
    logic snooze_unused;
    assign snooze_unused = snooze;
`endif

    // Priority: stop, then snooze/snooze re-sound, then fresh trigger, then timeout.
    always_comb begin
        sound_d  = sound_q;
        id_d     = id_q;
        to_cnt_d = to_cnt_q;
`ifdef MULTI_ALARM_SNOOZE_EN
        pend_d = pend_q;
        tgt_d  = tgt_q;
`endif
        if (stop_alarm) begin
            sound_d = 1'b0;
`ifdef MULTI_ALARM_SNOOZE_EN
            pend_d = 1'b0;
        end else if (sound_q && snooze) begin
            sound_d = 1'b0;
            pend_d  = 1'b1;
            tgt_d   = (snz_sum >= 11'd1440) ? snz_sum - 11'd1440 : snz_sum;
        end else if (!sound_q && pend_q && tick_eff && nx_total == tgt_q) begin
            sound_d  = 1'b1;
            pend_d   = 1'b0;
            to_cnt_d = '0;
`endif
        end else if (!sound_q && tick_eff && hit) begin
            sound_d  = 1'b1;
            id_d     = hit_id;
            to_cnt_d = '0;
        end else if (sound_q && tick_eff) begin
            if (to_cnt_q == TO_W'(TIMEOUT_MIN - 1)) sound_d  = 1'b0;
            else                                    to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_comb begin
        case (state_q)
            ENTRY:      shown = entry;
            SHOW_ALARM: shown = (sel_ok && alarm_en_q[alarm_sel]) ? alarm_q[alarm_sel] : '0;
            default:    shown = to_hhmm(hr_q, min_q);
        endcase
        disp_d = {ASCII_ZERO + {4'h0, shown.ms_hr},  ASCII_ZERO + {4'h0, shown.ls_hr},
                  ASCII_ZERO + {4'h0, shown.ms_min}, ASCII_ZERO + {4'h0, shown.ls_min}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q    <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hr_q       <= '0;
            state_q    <= SHOW_TIME;
            ent_cnt_q  <= '0;
            alarm_q    <= '{default: '0};
            alarm_en_q <= '0;
            sound_q    <= 1'b0;
            id_q       <= '0;
            to_cnt_q   <= '0;
            disp_q     <= {4{ASCII_ZERO}};
`ifdef MULTI_ALARM_SNOOZE_EN
            pend_q     <= 1'b0;
            tgt_q      <= '0;
`endif
        end else begin
            if (load_time) begin
                hr_q    <= hhmm_hours(entry);
                min_q   <= hhmm_minutes(entry);
                sec_q   <= '0;
                presc_q <= '0;
            end else begin
                if (fast_watch) begin
                    presc_q <= '0;
                    sec_q   <= '0;
                end else begin
                    presc_q <= sec_tick ? '0 : presc_q + 1'b1;
                    if (sec_tick) sec_q <= (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
                end
                if (min_tick) begin
                    min_q <= min_nx;
                    hr_q  <= hr_nx;
                end
            end
            if (store_alarm) begin
                alarm_q[alarm_sel]    <= entry;
                alarm_en_q[alarm_sel] <= 1'b1;
            end
            ent_cnt_q <= (state_q != ENTRY || accept) ? '0 : ent_cnt_q + 1'b1;
            state_q   <= state_d;
            sound_q   <= sound_d;
            id_q      <= id_d;
            to_cnt_q  <= to_cnt_d;
            disp_q    <= disp_d;
`ifdef MULTI_ALARM_SNOOZE_EN
            pend_q    <= pend_d;
            tgt_q     <= tgt_d;
`endif
        end
    end

    assign sound_alarm    = sound_q;
    assign alarm_id       = id_q;
    assign display_ms_hr  = disp_q[31:24];
    assign display_ls_hr  = disp_q[23:16];
    assign display_ms_min = disp_q[15:8];
    assign display_ls_min = disp_q[7:0];

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Scoreboard bench for multi_alarm_clock; snooze expectations follow MULTI_ALARM_SNOOZE_EN.
module tb_multi_alarm_clock;

`ifdef MULTI_ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       alarm_button = 1'b0, time_button = 1'b0;
    logic [3:0] key = 4'd10;
    logic [1:0] alarm_sel = 2'd0;
    logic       fast_watch = 1'b0, stop_alarm = 1'b0, snooze = 1'b0;
    logic       sound_alarm;
    logic [1:0] alarm_id;
    logic [7:0] display_ms_hr, display_ls_hr, display_ms_min, display_ls_min;
    logic [31:0] disp_w;

    typedef struct {
        string       tag;
        logic [31:0] disp;
        logic        snd;
        logic [1:0]  id;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    multi_alarm_clock #(.CLK_HZ(256), .NUM_ALARMS(4), .TIMEOUT_MIN(2), .SNOOZE_MIN(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .alarm_button   (alarm_button),
        .time_button    (time_button),
        .key            (key),
        .alarm_sel      (alarm_sel),
        .fast_watch     (fast_watch),
        .stop_alarm     (stop_alarm),
        .snooze         (snooze),
        .sound_alarm    (sound_alarm),
        .alarm_id       (alarm_id),
        .display_ms_hr  (display_ms_hr),
        .display_ls_hr  (display_ls_hr),
        .display_ms_min (display_ms_min),
        .display_ls_min (display_ls_min)
    );

    always #5 clk = ~clk;
    assign disp_w = {display_ms_hr, display_ls_hr, display_ms_min, display_ls_min};

    function automatic logic [31:0] asc(input int unsigned h, input int unsigned m);
        return {8'(48 + h / 10), 8'(48 + h % 10), 8'(48 + m / 10), 8'(48 + m % 10)};
    endfunction

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] d);
        key = d;
        tick(1);
        key = 4'd10;
        tick(1);
    endtask

    task automatic enter4(input logic [3:0] a, b, c, d);
        press(a); press(b); press(c); press(d);
    endtask

    task automatic set_time(input logic [3:0] a, b, c, d);
        enter4(a, b, c, d);
        time_button = 1'b1; tick(1); time_button = 1'b0; tick(1);
    endtask

    task automatic store_alarm(input logic [1:0] slot, input logic [3:0] a, b, c, d);
        alarm_sel = slot;
        enter4(a, b, c, d);
        alarm_button = 1'b1; tick(1); alarm_button = 1'b0; tick(1);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        sb.push_back('{"reset", asc(0, 0), 1'b0, 2'd0});
        tick(3);
        e = sb.pop_front(); checks += 3;
        if (disp_w !== e.disp) begin errors++; $display("FAIL %s display got %h exp %h", e.tag, disp_w, e.disp); end
        if (sound_alarm !== e.snd) begin errors++; $display("FAIL %s sound got %b exp %b", e.tag, sound_alarm, e.snd); end
        if (alarm_id !== e.id) begin errors++; $display("FAIL %s alarm_id got %0d exp %0d", e.tag, alarm_id, e.id); end
        reset = 1'b0;
    endtask

    task automatic test_time_count;
        sb.push_back('{"before_1min", asc(0, 0), 1'b0, 2'd0});
        sb.push_back('{"after_1min", asc(0, 1), 1'b0, 2'd0});
        for (int k = 0; k < 2; k++) begin
            tick(k == 0 ? 15355 : 10);
            e = sb.pop_front(); checks += 3;
            if (disp_w !== e.disp) begin errors++; $display("FAIL %s display got %h exp %h", e.tag, disp_w, e.disp); end
            if (sound_alarm !== e.snd) begin errors++; $display("FAIL %s sound got %b exp %b", e.tag, sound_alarm, e.snd); end
            if (alarm_id !== e.id) begin errors++; $display("FAIL %s alarm_id got %0d exp %0d", e.tag, alarm_id, e.id); end
        end
    endtask

    task automatic test_time_entry;
        enter4(1, 2, 3, 4);
        sb.push_back('{"entry_buf", asc(12, 34), 1'b0, 2'd0});
        e = sb.pop_front(); checks++;
        if (disp_w !== e.disp) begin errors++; $display("FAIL %s display got %h exp %h", e.tag, disp_w, e.disp); end
        time_button = 1'b1; tick(1); time_button = 1'b0;
        sb.push_back('{"load_1234", asc(12, 34), 1'b0, 2'd0});
        sb.push_back('{"load_secs0", asc(12, 35), 1'b0, 2'd0});
        for (int k = 0; k < 2; k++) begin
            tick(k == 0 ? 15355 : 10);
            e = sb.pop_front(); checks++;
            if (disp_w !== e.disp) begin errors++; $display("FAIL %s display got %h exp %h", e.tag, disp_w, e.disp); end
        end
        set_time(2, 5, 0, 0);
        sb.push_back('{"invalid_2500", asc(12, 35), 1'b0, 2'd0});
        tick(1);
        e = sb.pop_front(); checks++;
        if (disp_w !== e.disp) begin errors++; $display("FAIL %s display got %h exp %h", e.tag, disp_w, e.disp); end
    endtask

    task automatic test_alarm_trigger;
        store_alarm(2, 0, 6, 3, 0);
        store_alarm(1, 0, 6, 3, 0);
        alarm_sel = 2; alarm_button = 1'b1;
        sb.push_back('{"show_slot2", asc(6, 30), 1'b0, 2'd0});
        sb.push_back('{"show_slot3", asc(0, 0), 1'b0, 2'd0});
        for (int k = 0; k < 2; k++) begin
            if (k == 1) alarm_sel = 3;
            tick(2);
            e = sb.pop_front(); checks++;
            if (disp_w !== e.disp) begin errors++; $display("FAIL %s display got %h exp %h", e.tag, disp_w, e.disp); end
        end
        alarm_button = 1'b0; tick(2);
        set_time(0, 6, 2, 9);
        fast_watch = 1'b1;
        sb.push_back('{"trigger", asc(6, 29), 1'b1, 2'd1});
        sb.push_back('{"timeout_1", asc(6, 30), 1'b1, 2'd1});
        sb.push_back('{"timeout_2", asc(6, 31), 1'b0, 2'd1});
        for (int k = 0; k < 3; k++) begin
            tick(1);
            e = sb.pop_front(); checks += 3;
            if (disp_w !== e.disp) begin errors++; $display("FAIL %s display got %h exp %h", e.tag, disp_w, e.disp); end
            if (sound_alarm !== e.snd) begin errors++; $display("FAIL %s sound got %b exp %b", e.tag, sound_alarm, e.snd); end
            if (alarm_id !== e.id) begin errors++; $display("FAIL %s alarm_id got %0d exp %0d", e.tag, alarm_id, e.id); end
        end
        fast_watch = 1'b0; tick(1);
        // stop_alarm on the trigger cycle must keep the buzzer silent
        set_time(0, 6, 2, 9);
        fast_watch = 1'b1; stop_alarm = 1'b1;
        sb.push_back('{"stop_on_trigger", asc(6, 29), 1'b0, 2'd1});
        tick(1);
        fast_watch = 1'b0; stop_alarm = 1'b0;
        e = sb.pop_front(); checks += 2;
        if (disp_w !== e.disp) begin errors++; $display("FAIL %s display got %h exp %h", e.tag, disp_w, e.disp); end
        if (sound_alarm !== e.snd) begin errors++; $display("FAIL %s sound got %b exp %b", e.tag, sound_alarm, e.snd); end
    endtask

    task automatic test_midnight;
        store_alarm(0, 0, 0, 0, 0);
        set_time(2, 3, 5, 9);
        fast_watch = 1'b1;
        sb.push_back('{"midnight_trig", asc(23, 59), 1'b1, 2'd0});
        sb.push_back('{"midnight_wrap", asc(0, 0), 1'b1, 2'd0});
        sb.push_back('{"stop", asc(0, 0), 1'b0, 2'd0});
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin stop_alarm = 1'b1; tick(1); stop_alarm = 1'b0; end
            tick(1);
            fast_watch = 1'b0;
            e = sb.pop_front(); checks += 3;
            if (disp_w !== e.disp) begin errors++; $display("FAIL %s display got %h exp %h", e.tag, disp_w, e.disp); end
            if (sound_alarm !== e.snd) begin errors++; $display("FAIL %s sound got %b exp %b", e.tag, sound_alarm, e.snd); end
            if (alarm_id !== e.id) begin errors++; $display("FAIL %s alarm_id got %0d exp %0d", e.tag, alarm_id, e.id); end
        end
    endtask

    task automatic test_held_key;
        key = 4'd7; tick(100); key = 4'd10;
        sb.push_back('{"held_key", asc(0, 7), 1'b0, 2'd0});
        sb.push_back('{"before_timeout", asc(0, 7), 1'b0, 2'd0});
        sb.push_back('{"entry_timeout", asc(0, 0), 1'b0, 2'd0});
        for (int k = 0; k < 3; k++) begin
            tick(k == 0 ? 1 : (k == 1 ? 2450 : 15));
            e = sb.pop_front(); checks++;
            if (disp_w !== e.disp) begin errors++; $display("FAIL %s display got %h exp %h", e.tag, disp_w, e.disp); end
        end
    endtask

    task automatic test_snooze;
        store_alarm(3, 0, 7, 0, 0);
        set_time(0, 6, 5, 9);
        fast_watch = 1'b1;
        sb.push_back('{"trig_0700", asc(6, 59), 1'b1, 2'd3});
        tick(1);
        fast_watch = 1'b0;
        e = sb.pop_front(); checks += 2;
        if (sound_alarm !== e.snd) begin errors++; $display("FAIL %s sound got %b exp %b", e.tag, sound_alarm, e.snd); end
        if (alarm_id !== e.id) begin errors++; $display("FAIL %s alarm_id got %0d exp %0d", e.tag, alarm_id, e.id); end
        snooze = 1'b1;
        sb.push_back('{"snooze", asc(7, 0), !SNZ, 2'd3});
        tick(1);
        snooze = 1'b0;
        sb.push_back('{"snooze_wait", asc(7, 3), 1'b0, 2'd3});
        sb.push_back('{"snooze_resound", asc(7, 4), SNZ, 2'd3});
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin fast_watch = 1'b1; tick(4); end
            if (k == 2) begin tick(1); fast_watch = 1'b0; end
            e = sb.pop_front(); checks += 3;
            if (disp_w !== e.disp) begin errors++; $display("FAIL %s display got %h exp %h", e.tag, disp_w, e.disp); end
            if (sound_alarm !== e.snd) begin errors++; $display("FAIL %s sound got %b exp %b", e.tag, sound_alarm, e.snd); end
            if (alarm_id !== e.id) begin errors++; $display("FAIL %s alarm_id got %0d exp %0d", e.tag, alarm_id, e.id); end
        end
        stop_alarm = 1'b1;
        sb.push_back('{"final_stop", asc(7, 5), 1'b0, 2'd3});
        tick(1); stop_alarm = 1'b0; tick(1);
        e = sb.pop_front(); checks += 2;
        if (disp_w !== e.disp) begin errors++; $display("FAIL %s display got %h exp %h", e.tag, disp_w, e.disp); end
        if (sound_alarm !== e.snd) begin errors++; $display("FAIL %s sound got %b exp %b", e.tag, sound_alarm, e.snd); end
    endtask

    initial begin
        test_reset();
        test_time_count();
        test_time_entry();
        test_alarm_trigger();
        test_midnight();
        test_held_key();
        test_snooze();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
